// File: rtl/lsab_cr_pkg.sv
// lsab_cr_pkg: shared sizing constants for the lsab_cr load/store alignment buffer
package lsab_cr_pkg;
    localparam int DEPTH_LOG2_DEF = 5;
    localparam int WIDTH_DEF      = 32;
    localparam int LANE_W         = 2;
    localparam int NUM_LANES      = 1 << LANE_W;
endpackage

// File: rtl/lsab_cr_lane.sv
// lsab_lane: single-lane synchronous FIFO of {tag, data} entries.
// Ports: clk/rst_n (async active-low), push/pop requests, wdata/wint entry to push,
// head_data (current head word), empty (current state), nxt_empty/nxt_head_int
// (lane state as it will be after this edge, for registered status outputs).
module lsab_lane
    import lsab_cr_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int WIDTH      = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wint,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             nxt_empty,
    output logic             nxt_head_int
);
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
    logic [WIDTH:0]        mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wptr, rptr, nxt_rptr;
    logic [DEPTH_LOG2:0]   count, nxt_count;
    logic                  pop_ok, push_ok, head_is_new;
    assign empty     = count == '0;
    assign pop_ok    = pop && !empty;
    // a pop in the same cycle frees a slot, so a full lane still accepts the push
    assign push_ok   = push && (count != FULL || pop_ok);
    assign nxt_rptr  = rptr + DEPTH_LOG2'(pop_ok);
    assign nxt_count = count + (DEPTH_LOG2+1)'(push_ok) - (DEPTH_LOG2+1)'(pop_ok);
    assign nxt_empty = nxt_count == '0;
    // when the lane drains to zero this cycle, the next head is the entry being written now
    assign head_is_new  = empty || (count == (DEPTH_LOG2+1)'(1) && pop_ok);
    assign nxt_head_int = head_is_new ? wint : mem[nxt_rptr][WIDTH];
    assign head_data    = mem[rptr][WIDTH-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + DEPTH_LOG2'(push_ok);
            rptr  <= nxt_rptr;
            count <= nxt_count;
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= {wint, wdata};
    end
endmodule

// File: rtl/lsab_cr.sv
// lsab_cr: four-lane load/store alignment buffer with a shared registered pop output.
// Ports: CLK, RST (async active-low); WRITE/WRITE_FIFO/IN_n/INT_IN_n push one lane;
// READ/READ_FIFO pop one lane onto OUT (latency 1); CAREOF_INT_n enables tag STOP;
// EMPTY_n/STOP_n are registered per-lane status for the lane scheduler.
module lsab_cr
    import lsab_cr_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int WIDTH      = WIDTH_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WRITE,
    input  logic [LANE_W-1:0] WRITE_FIFO,
    input  logic [WIDTH-1:0]  IN_0,
    input  logic [WIDTH-1:0]  IN_1,
    input  logic [WIDTH-1:0]  IN_2,
    input  logic [WIDTH-1:0]  IN_3,
    input  logic              INT_IN_0,
    input  logic              INT_IN_1,
    input  logic              INT_IN_2,
    input  logic              INT_IN_3,
    input  logic              READ,
    input  logic [LANE_W-1:0] READ_FIFO,
    input  logic              CAREOF_INT_0,
    input  logic              CAREOF_INT_1,
    input  logic              CAREOF_INT_2,
    input  logic              CAREOF_INT_3,
    output logic [WIDTH-1:0]  OUT,
    output logic              EMPTY_0,
    output logic              EMPTY_1,
    output logic              EMPTY_2,
    output logic              EMPTY_3,
    output logic              STOP_0,
    output logic              STOP_1,
    output logic              STOP_2,
    output logic              STOP_3
);
    logic [WIDTH-1:0]     din  [NUM_LANES];
    logic [WIDTH-1:0]     head [NUM_LANES];
    logic [NUM_LANES-1:0] din_int, careof, empty, nxt_empty, nxt_head_int, empty_q, stop_q;
    assign din     = '{IN_0, IN_1, IN_2, IN_3};
    assign din_int = {INT_IN_3, INT_IN_2, INT_IN_1, INT_IN_0};
    assign careof  = {CAREOF_INT_3, CAREOF_INT_2, CAREOF_INT_1, CAREOF_INT_0};
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lsab_lane #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WIDTH)) u_lane (
            .clk          (CLK),
            .rst_n        (RST),
            .push         (WRITE && WRITE_FIFO == LANE_W'(i)),
            .pop          (READ && READ_FIFO == LANE_W'(i)),
            .wdata        (din[i]),
            .wint         (din_int[i]),
            .head_data    (head[i]),
            .empty        (empty[i]),
            .nxt_empty    (nxt_empty[i]),
            .nxt_head_int (nxt_head_int[i])
        );
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OUT     <= '0;
            empty_q <= '1;
            stop_q  <= '0;
        end else begin
            if (READ && !empty[READ_FIFO]) OUT <= head[READ_FIFO];
            empty_q <= nxt_empty;
            stop_q  <= ~nxt_empty & nxt_head_int & careof;
        end
    end
    assign {EMPTY_3, EMPTY_2, EMPTY_1, EMPTY_0} = empty_q;
    assign {STOP_3, STOP_2, STOP_1, STOP_0}     = stop_q;
endmodule

// File: tb/tb_lsab_cr.sv
// tb_lsab_cr: directed self-checking bench for lsab_cr
module tb_lsab_cr;
    logic        clk = 1'b0, rst = 1'b0, write = 1'b0, read = 1'b0;
    logic [1:0]  write_fifo = '0, read_fifo = '0;
    logic [31:0] in_a [4];
    logic [3:0]  int_a = '0, careof = '0;
    logic [31:0] out_w;
    logic [3:0]  empty_v, stop_v;
    int          checks = 0, errors = 0;

    lsab_cr dut (
        .CLK(clk), .RST(rst), .WRITE(write), .WRITE_FIFO(write_fifo),
        .IN_0(in_a[0]), .IN_1(in_a[1]), .IN_2(in_a[2]), .IN_3(in_a[3]),
        .INT_IN_0(int_a[0]), .INT_IN_1(int_a[1]), .INT_IN_2(int_a[2]), .INT_IN_3(int_a[3]),
        .READ(read), .READ_FIFO(read_fifo),
        .CAREOF_INT_0(careof[0]), .CAREOF_INT_1(careof[1]),
        .CAREOF_INT_2(careof[2]), .CAREOF_INT_3(careof[3]),
        .OUT(out_w),
        .EMPTY_0(empty_v[0]), .EMPTY_1(empty_v[1]), .EMPTY_2(empty_v[2]), .EMPTY_3(empty_v[3]),
        .STOP_0(stop_v[0]), .STOP_1(stop_v[1]), .STOP_2(stop_v[2]), .STOP_3(stop_v[3])
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_write(input int l, input logic [31:0] v, input logic t);
        write      = 1'b1;
        write_fifo = l[1:0];
        for (int k = 0; k < 4; k++) in_a[k] = (k == l) ? v : ~v;
        int_a      = {4{~t}};
        int_a[l]   = t;
    endtask

    task automatic push(input int l, input logic [31:0] v, input logic t);
        set_write(l, v, t);
        tick();
        write = 1'b0;
    endtask

    task automatic pop(input int l);
        read      = 1'b1;
        read_fifo = l[1:0];
        tick();
        read = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) in_a[k] = '0;
        tick();
        tick();
        chk("rst_empty", {28'h0, empty_v}, 32'hF);
        chk("rst_stop", {28'h0, stop_v}, 32'h0);
        chk("rst_out", out_w, 32'h0);
        rst = 1'b1;
        tick();
        chk("idle_empty", {28'h0, empty_v}, 32'hF);
        chk("idle_stop", {28'h0, stop_v}, 32'h0);
        chk("idle_out", out_w, 32'h0);

        push(2, 32'h2000_0005, 1'b0);
        chk("push2_empty", {28'h0, empty_v}, 32'hB);
        pop(2);
        chk("pop2_out", out_w, 32'h2000_0005);
        chk("pop2_empty", {28'h0, empty_v}, 32'hF);

        for (int i = 0; i < 4; i++)
            for (int l = 0; l < 4; l++) push(l, {2'h0, l[1:0], 28'(i)}, 1'b0);
        chk("rr_empty", {28'h0, empty_v}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            pop(1);
            chk("rr_pop1", out_w, 32'h1000_0000 + 32'(i));
        end
        chk("rr_empty_after", {28'h0, empty_v}, 32'h2);
        pop(1);
        chk("empty_read_hold", out_w, 32'h1000_0003);

        #3 rst = 1'b0;
        #1;
        chk("async_rst_empty", {28'h0, empty_v}, 32'hF);
        chk("async_rst_out", out_w, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rst_empty", {28'h0, empty_v}, 32'hF);

        careof[3] = 1'b1;
        push(3, 32'h3000_0001, 1'b1);
        chk("stop3_set", {28'h0, stop_v}, 32'h8);
        careof[3] = 1'b0;
        tick();
        chk("stop3_nocare", {28'h0, stop_v}, 32'h0);
        careof[3] = 1'b1;
        tick();
        chk("stop3_care", {28'h0, stop_v}, 32'h8);
        pop(3);
        chk("stop3_pop_stop", {28'h0, stop_v}, 32'h0);
        chk("stop3_pop_empty", {28'h0, empty_v}, 32'hF);
        chk("stop3_pop_out", out_w, 32'h3000_0001);
        push(3, 32'h3000_000A, 1'b0);
        push(3, 32'h3000_000B, 1'b1);
        chk("stop3_untagged_head", {28'h0, stop_v}, 32'h0);
        pop(3);
        chk("stop3_tagged_head", {28'h0, stop_v}, 32'h8);
        chk("stop3_out_a", out_w, 32'h3000_000A);
        pop(3);
        chk("stop3_drained", {28'h0, stop_v}, 32'h0);
        chk("stop3_out_b", out_w, 32'h3000_000B);
        careof[3] = 1'b0;

        for (int i = 0; i < 33; i++) push(0, 32'(i), 1'b0);
        chk("fill_empty", {28'h0, empty_v}, 32'hE);
        for (int i = 0; i < 32; i++) begin
            pop(0);
            chk("fill_pop", out_w, 32'(i));
        end
        chk("fill_drained", {28'h0, empty_v}, 32'hF);

        push(0, 32'hA, 1'b0);
        set_write(0, 32'hB, 1'b0);
        read      = 1'b1;
        read_fifo = 2'd0;
        tick();
        write = 1'b0;
        read  = 1'b0;
        chk("rw_same_out", out_w, 32'hA);
        chk("rw_same_empty", {28'h0, empty_v}, 32'hE);
        pop(0);
        chk("rw_same_next", out_w, 32'hB);
        chk("rw_same_drained", {28'h0, empty_v}, 32'hF);

        set_write(1, 32'hC, 1'b0);
        read      = 1'b1;
        read_fifo = 2'd1;
        tick();
        write = 1'b0;
        read  = 1'b0;
        chk("rw_empty_out", out_w, 32'hB);
        chk("rw_empty_empty", {28'h0, empty_v}, 32'hD);
        pop(1);
        chk("rw_empty_pop", out_w, 32'hC);

        push(2, 32'hD, 1'b0);
        set_write(1, 32'hE, 1'b0);
        read      = 1'b1;
        read_fifo = 2'd2;
        tick();
        write = 1'b0;
        read  = 1'b0;
        chk("rw_diff_out", out_w, 32'hD);
        chk("rw_diff_empty", {28'h0, empty_v}, 32'hD);
        pop(1);
        chk("rw_diff_pop", out_w, 32'hE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
